amount_display_driver: RTL and testbench

Reads the dispenser's `total_amount_in_ml` and `current_state` outputs and drives a multiplexed, active-low seven-segment display. It performs a serial binary-to-BCD conversion (double dabble), updates the shown value atomically, and scans one digit at a time. It sits between `water_dispenser` and the board display pins.

---
 rtl/amount_display_pkg.sv | 41 ++++
 rtl/bin_to_bcd_serial.sv | 104 ++++++++++
 rtl/amount_display_driver.sv | 92 +++++++++
 tb/tb_amount_display_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amount_display_pkg.sv
// Shared types and seven-segment encoding for the amount display driver.
// Segment patterns are active-low, bit order g..a.
package amount_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_segments(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: captures a changed amount, clamps it to the
// largest displayable value and publishes the BCD result atomically.
module bin_to_bcd_serial #(
  parameter int AMOUNT_WIDTH = 14,
  parameter int DIGIT_COUNT  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [AMOUNT_WIDTH-1:0]  amount,
  output logic                     busy,
  output logic [4*DIGIT_COUNT-1:0] bcd
);
  import amount_display_pkg::*;

  localparam int BCD_W = 4 * DIGIT_COUNT;
  localparam int CNT_W = $clog2(AMOUNT_WIDTH + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGIT_COUNT) - 64'd1;

  state_t                  state_q, state_d;
  logic [AMOUNT_WIDTH-1:0] captured_q, captured_d;
  logic [AMOUNT_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic                    busy_q, busy_d;

  logic [AMOUNT_WIDTH-1:0]       clamped;
  logic [BCD_W-1:0]              adjusted;
  logic [BCD_W+AMOUNT_WIDTH-1:0] shifted;

  always_comb begin
    clamped = amount;
    if (64'(amount) > MAX_VAL) clamped = AMOUNT_WIDTH'(MAX_VAL);

    adjusted = acc_q;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (adjusted[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = adjusted[4*i +: 4] + 4'd3;
    end
    shifted = {adjusted, shift_q} << 1;

    state_d    = state_q;
    captured_d = captured_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // Compare against the raw captured amount so a saturated input does not retrigger forever.
        if (amount != captured_q) begin
          captured_d = amount;
          shift_d    = clamped;
          acc_d      = '0;
          count_d    = CNT_W'(AMOUNT_WIDTH);
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        busy_d  = 1'b1;
        acc_d   = shifted[BCD_W+AMOUNT_WIDTH-1 -: BCD_W];
        shift_d = shifted[AMOUNT_WIDTH-1:0];
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = LOAD;
      end
      LOAD: begin
        busy_d  = 1'b1;
        bcd_d   = acc_q;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      captured_q <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/amount_display_driver.sv
// Multiplexed active-low seven-segment driver for the dispensed amount.
// Define AMOUNT_DISPLAY_BLANK_EN to blank leading zeros.
module amount_display_driver #(
  parameter int DIGIT_COUNT    = 4,
  parameter int AMOUNT_WIDTH   = 14,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AMOUNT_WIDTH-1:0] total_amount_in_ml,
  input  logic                    current_state,
  output logic [6:0]              segments_n,
  output logic                    dp_n,
  output logic [DIGIT_COUNT-1:0]  digit_enable_n,
  output logic                    busy
);
  import amount_display_pkg::*;

  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  logic [4*DIGIT_COUNT-1:0] display_bcd;
  logic [REF_W-1:0]         refresh_count_q, refresh_count_d;
  logic [IDX_W-1:0]         digit_index_q, digit_index_d;
  logic [6:0]               segments_q, segments_d;
  logic                     dp_q, dp_d;
  logic [DIGIT_COUNT-1:0]   enable_q, enable_d;
  logic [DIGIT_COUNT-1:0]   blank;
  logic [3:0]               nibble;

  bin_to_bcd_serial #(
    .AMOUNT_WIDTH(AMOUNT_WIDTH),
    .DIGIT_COUNT (DIGIT_COUNT)
  ) u_conv (
    .clock (clock),
    .reset (reset),
    .amount(total_amount_in_ml),
    .busy  (busy),
    .bcd   (display_bcd)
  );

`ifdef AMOUNT_DISPLAY_BLANK_EN
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = DIGIT_COUNT - 1; i > 0; i--) begin
      if (display_bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      blank[i] = ~seen;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    refresh_count_d = refresh_count_q + REF_W'(1);
    digit_index_d   = digit_index_q;
    if (refresh_count_q == REF_W'(REFRESH_CYCLES - 1)) begin
      refresh_count_d = '0;
      if (digit_index_q == IDX_W'(DIGIT_COUNT - 1)) digit_index_d = '0;
      else digit_index_d = digit_index_q + IDX_W'(1);
    end

    // All three outputs come from the same index so the enable and pattern never skew.
    nibble     = display_bcd[4*int'(digit_index_q) +: 4];
    segments_d = blank[digit_index_q] ? SEG_BLANK : bcd_to_segments(nibble);
    enable_d   = ~(DIGIT_COUNT'(1) << digit_index_q);
    dp_d       = ~((digit_index_q == '0) && current_state);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_count_q <= '0;
      digit_index_q   <= '0;
      segments_q      <= SEG_0;
      dp_q            <= 1'b1;
      enable_q        <= ~DIGIT_COUNT'(1);
    end else begin
      refresh_count_q <= refresh_count_d;
      digit_index_q   <= digit_index_d;
      segments_q      <= segments_d;
      dp_q            <= dp_d;
      enable_q        <= enable_d;
    end
  end

  assign segments_n     = segments_q;
  assign dp_n           = dp_q;
  assign digit_enable_n = enable_q;

endmodule

// File: tb/tb_amount_display_driver.sv
// Self-checking bench for amount_display_driver with a short refresh period;
// expectations follow AMOUNT_DISPLAY_BLANK_EN when it is defined.
module tb_amount_display_driver;

  localparam int DC = 4;
  localparam int AW = 14;
  localparam int RC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] amt;
  logic          cs;
  logic [6:0]    segments_n;
  logic          dp_n;
  logic [DC-1:0] digit_enable_n;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [10];

  typedef struct {
    int unsigned     amount;
    logic            cs;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t vecs [10];

  amount_display_driver #(
    .DIGIT_COUNT   (DC),
    .AMOUNT_WIDTH  (AW),
    .REFRESH_CYCLES(RC)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .total_amount_in_ml(amt),
    .current_state     (cs),
    .segments_n        (segments_n),
    .dp_n              (dp_n),
    .digit_enable_n    (digit_enable_n),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned pow10(input int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal model: saturate, pick the digit arithmetically, blank above the top digit.
  function automatic logic [6:0] model_seg(input int unsigned a, input int idx);
    int unsigned v;
    v = (a > 9999) ? 9999 : a;
`ifdef AMOUNT_DISPLAY_BLANK_EN
    if (idx > 0 && v < pow10(idx)) return 7'h7F;
`endif
    return seg_tab[(v / pow10(idx)) % 10];
  endfunction

  function automatic logic [3:0][6:0] model_digits(input int unsigned a);
    logic [3:0][6:0] r;
    for (int i = 0; i < DC; i++) r[i] = model_seg(a, i);
    return r;
  endfunction

  function automatic logic [3:0][6:0] fix_blank(input logic [3:0][6:0] e);
    logic [3:0][6:0] r = e;
`ifndef AMOUNT_DISPLAY_BLANK_EN
    for (int i = 0; i < DC; i++) if (r[i] == 7'h7F) r[i] = 7'h40;
`endif
    return r;
  endfunction

  function automatic int enabled_idx(input logic [DC-1:0] den);
    int r = -1;
    int c = 0;
    for (int i = 0; i < DC; i++) if (!den[i]) begin r = i; c++; end
    return (c == 1) ? r : -1;
  endfunction

  function automatic vec_t mkv(input int unsigned a, input logic c,
                               input logic [6:0] d0, input logic [6:0] d1,
                               input logic [6:0] d2, input logic [6:0] d3);
    vec_t v;
    v.amount = a;
    v.cs     = c;
    v.exp    = {d3, d2, d1, d0};
    return v;
  endfunction

  task automatic applyStimulus(input int unsigned a, input logic c);
    @(negedge clock);
    amt = AW'(a);
    cs  = c;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(posedge clock); #1;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, " busy_timeout"}, busy, 0);
  endtask

  // One full scan: every digit must appear exactly RC cycles with the right pattern.
  task automatic checkOutput(input string name, input logic [3:0][6:0] exp, input logic c);
    int seen [DC];
    int idx;
    for (int d = 0; d < DC; d++) seen[d] = 0;
    for (int k = 0; k < DC * RC; k++) begin
      @(negedge clock);
      idx = enabled_idx(digit_enable_n);
      check({name, " onehot"}, (idx >= 0) ? 1 : 0, 1);
      if (idx >= 0) begin
        seen[idx]++;
        check($sformatf("%s seg d%0d", name, idx), segments_n, exp[idx]);
        check($sformatf("%s dp d%0d", name, idx), dp_n, (idx == 0 && c) ? 0 : 1);
      end
    end
    for (int d = 0; d < DC; d++) check($sformatf("%s dwell d%0d", name, d), seen[d], RC);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " den"}, digit_enable_n, 4'b1110);
    check({name, " seg"}, segments_n, 7'b1000000);
    check({name, " dp"}, dp_n, 1);
    check({name, " busy"}, busy, 0);
  endtask

  initial begin
    int hi;
    int idx;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    vecs[0] = mkv(640,   0, 7'h40, 7'h19, 7'h02, 7'h7F);
    vecs[1] = mkv(1380,  0, 7'h40, 7'h00, 7'h30, 7'h79);
    vecs[2] = mkv(12000, 0, 7'h10, 7'h10, 7'h10, 7'h10);
    vecs[3] = mkv(9999,  1, 7'h10, 7'h10, 7'h10, 7'h10);
    vecs[4] = mkv(640,   1, 7'h40, 7'h19, 7'h02, 7'h7F);
    vecs[5] = mkv(0,     0, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    vecs[6] = mkv(7,     1, 7'h78, 7'h7F, 7'h7F, 7'h7F);
    vecs[7] = mkv(10000, 0, 7'h10, 7'h10, 7'h10, 7'h10);
    vecs[8] = mkv(1005,  1, 7'h12, 7'h40, 7'h40, 7'h79);
    vecs[9] = mkv(16383, 0, 7'h10, 7'h10, 7'h10, 7'h10);

    reset = 1'b1;
    amt   = '0;
    cs    = 1'b0;
    #12;
    check_reset_outputs("por");
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(640, 0);
    hi = 0;
    @(posedge clock); #1;
    while (busy && hi < 100) begin
      hi++;
      @(posedge clock); #1;
    end
    check("busy_len_640", hi, 16);
    checkOutput("first_640", fix_blank(vecs[0].exp), 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].amount, vecs[i].cs);
      wait_idle($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_%0d", i, vecs[i].amount), fix_blank(vecs[i].exp), vecs[i].cs);
    end

    // Amount changes four cycles into a conversion: 0 -> 640 -> 1380, never a mix.
    @(negedge clock);
    reset = 1'b1;
    amt   = '0;
    cs    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    amt = AW'(640);
    @(posedge clock); #1;
    check("chg busy_start", busy, 1);
    repeat (3) @(posedge clock);
    #1 amt = AW'(1380);
    repeat (11) @(posedge clock);
    #1;
    idx = enabled_idx(digit_enable_n);
    check("chg old_onehot", (idx >= 0) ? 1 : 0, 1);
    if (idx >= 0) check("chg old_seg", segments_n, model_seg(0, idx));
    @(posedge clock);
    @(posedge clock); #1;
    check("chg busy_restart", busy, 1);
    for (int k = 0; k < DC * RC; k++) begin
      idx = enabled_idx(digit_enable_n);
      check("chg mid_onehot", (idx >= 0) ? 1 : 0, 1);
      if (idx >= 0) check($sformatf("chg mid_seg d%0d", idx), segments_n, model_seg(640, idx));
      if (k < DC * RC - 1) begin
        @(posedge clock); #1;
      end
    end
    @(posedge clock); #1;
    idx = enabled_idx(digit_enable_n);
    check("chg new_onehot", (idx >= 0) ? 1 : 0, 1);
    if (idx >= 0) check("chg new_seg", segments_n, model_seg(1380, idx));
    wait_idle("chg");
    checkOutput("chg_1380", model_digits(1380), 0);

    // Asynchronous reset in the middle of a scan.
    repeat (5) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("scan_rst");
    @(negedge clock);
    reset = 1'b0;

    // Reset during a conversion aborts it; the held amount converts again afterwards.
    applyStimulus(5555, 1);
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("conv_rst");
    repeat (3) @(posedge clock);
    #1 check("conv_rst hold_den", digit_enable_n, 4'b1110);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("conv_rst restart_busy", busy, 1);
    wait_idle("conv_rst");
    checkOutput("conv_rst_5555", model_digits(5555), 1);

    for (int r = 0; r < 8; r++) begin
      int unsigned a;
      logic c;
      a = $urandom_range(0, 16383);
      c = 1'($urandom_range(0, 1));
      applyStimulus(a, c);
      wait_idle($sformatf("rnd%0d", r));
      checkOutput($sformatf("rnd%0d_%0d", r, a), model_digits(a), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
